path_encoder_8to3: RTL and testbench

//  Return-direction partner of the 3-to-8 path selector: collects requests on 8 one-hot

---
 rtl/path_encoder_8to3_pkg.sv | 24 ++
 rtl/rr_pick8.sv | 26 ++
 rtl/path_encoder_8to3.sv | 85 ++++++++
 tb/tb_path_encoder_8to3.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/path_encoder_8to3_pkg.sv
// Shared path/select definitions for the 8-to-3 path encoder and its 3-to-8 partner.
// Also holds the one-hot and population-count helpers used by the encoder datapath.
package path_encoder_8to3_pkg;

  localparam int unsigned PathN = 8;
  localparam int unsigned SelW  = 3;

  function automatic logic [PathN-1:0] onehot(input logic [SelW-1:0] sel);
    logic [PathN-1:0] r;
    r      = '0;
    r[sel] = 1'b1;
    return r;
  endfunction

  function automatic logic [3:0] popcount8(input logic [PathN-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < int'(PathN); i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Rotating-priority picker: first set bit of req scanning ptr, ptr+1, ... modulo 8.
module rr_pick8
  import path_encoder_8to3_pkg::*;
(
  input  logic [PathN-1:0] req,
  input  logic [SelW-1:0]  ptr,
  output logic             any,
  output logic [SelW-1:0]  idx
);

  logic [SelW-1:0] pos;

  always_comb begin
    any = 1'b0;
    idx = '0;
    pos = '0;
    for (int i = 0; i < int'(PathN); i++) begin
      pos = ptr + SelW'(i);
      if (!any && req[pos]) begin
        any = 1'b1;
        idx = pos;
      end
    end
  end

endmodule

// File: rtl/path_encoder_8to3.sv
// Collects one-hot path requests, latches them and re-encodes them to a 3-bit select,
// one code per handshake, served round-robin so simultaneous requests are never lost.
module path_encoder_8to3
  import path_encoder_8to3_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic               clk1,
  input  logic               rst1,
  input  logic [PathN-1:0]   path,
  input  logic               out_ready,
  output logic [SelW-1:0]    select,
  output logic               sel_valid,
  output logic [PathN-1:0]   pending,
  output logic [CNT_W-1:0]   merge_cnt
);

  logic [SelW-1:0]  select_q, select_d;
  logic             sel_valid_q, sel_valid_d;
  logic [PathN-1:0] pending_q, pending_d;
  logic [SelW-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0] merge_cnt_q, merge_cnt_d;

  logic [PathN-1:0] cand;
  logic             cand_any;
  logic [SelW-1:0]  pick;
  logic             load;
  logic [PathN-1:0] pick_mask;
  logic [PathN-1:0] clear_mask;
  logic [PathN-1:0] merges;
  logic [CNT_W:0]   merge_sum;

  assign cand = pending_q | path;

  rr_pick8 u_pick (
    .req (cand),
    .ptr (ptr_q),
    .any (cand_any),
    .idx (pick)
  );

  assign load      = (~sel_valid_q | out_ready) & cand_any;
  assign pick_mask = load ? onehot(pick) : '0;
  // A fresh request landing on an already-pending bit that is being loaded survives.
  assign clear_mask = pick_mask & ~(path & pending_q);
  assign merges     = path & pending_q & ~pick_mask;
  assign merge_sum  = {1'b0, merge_cnt_q} + (CNT_W + 1)'(popcount8(merges));

  always_comb begin
    select_d    = select_q;
    sel_valid_d = sel_valid_q;
    ptr_d       = ptr_q;
    if (load) begin
      select_d    = pick;
      sel_valid_d = 1'b1;
      ptr_d       = pick + 1'b1;
    end else if (out_ready) begin
      sel_valid_d = 1'b0;
    end
    pending_d   = cand & ~clear_mask;
    merge_cnt_d = merge_sum[CNT_W] ? {CNT_W{1'b1}} : merge_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk1 or posedge rst1) begin
    if (rst1) begin
      select_q    <= '0;
      sel_valid_q <= 1'b0;
      pending_q   <= '0;
      ptr_q       <= '0;
      merge_cnt_q <= '0;
    end else begin
      select_q    <= select_d;
      sel_valid_q <= sel_valid_d;
      pending_q   <= pending_d;
      ptr_q       <= ptr_d;
      merge_cnt_q <= merge_cnt_d;
    end
  end

  assign select    = select_q;
  assign sel_valid = sel_valid_q;
  assign pending   = pending_q;
  assign merge_cnt = merge_cnt_q;

endmodule

// File: tb/tb_path_encoder_8to3.sv
// Directed self-checking bench for path_encoder_8to3 with hand-computed expectations.
module tb_path_encoder_8to3;

  logic       clk1;
  logic       rst1;
  logic [7:0] path;
  logic       out_ready;
  logic [2:0] select;
  logic       sel_valid;
  logic [7:0] pending;
  logic [7:0] merge_cnt;

  int unsigned nvec;
  int unsigned nerr;

  path_encoder_8to3 #(.CNT_W(8)) dut (
    .clk1      (clk1),
    .rst1      (rst1),
    .path      (path),
    .out_ready (out_ready),
    .select    (select),
    .sel_valid (sel_valid),
    .pending   (pending),
    .merge_cnt (merge_cnt)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [2:0] s, input logic v,
                           input logic [7:0] p);
    check({tag, ".select"}, 8'(select), 8'(s));
    check({tag, ".valid"}, 8'(sel_valid), 8'(v));
    check({tag, ".pending"}, pending, p);
  endtask

  initial begin
    nvec      = 0;
    nerr      = 0;
    rst1      = 1'b1;
    path      = 8'h00;
    out_ready = 1'b0;
    #12;
    check_out("rst0", 3'd0, 1'b0, 8'h00);
    check("rst0.cnt", merge_cnt, 8'h00);
    @(negedge clk1);
    rst1 = 1'b0;

    // Burst from ptr=0: all eight codes in order.
    step();
    out_ready = 1'b1;
    path      = 8'hFF;
    step();
    check_out("burst0", 3'd0, 1'b1, 8'hFE);
    path = 8'h00;
    for (int i = 1; i < 8; i++) begin
      logic [7:0] ones;
      ones = 8'hFF;
      step();
      check_out($sformatf("burst%0d", i), 3'(i), 1'b1, ones << (i + 1));
    end
    step();
    check_out("burst_end", 3'd7, 1'b0, 8'h00);

    // Single request, ptr wraps to 0 after code 7 and then moves to 6.
    path = 8'h20;
    step();
    check_out("single", 3'd5, 1'b1, 8'h00);
    path = 8'h00;
    step();
    check_out("single_end", 3'd5, 1'b0, 8'h00);

    // Round-robin from ptr=6: 6 before 0, then 7 wraps ptr to 0.
    path = 8'h41;
    step();
    check_out("rr6", 3'd6, 1'b1, 8'h01);
    path = 8'h00;
    step();
    check_out("rr0", 3'd0, 1'b1, 8'h00);
    path = 8'h80;
    step();
    check_out("rr7", 3'd7, 1'b1, 8'h00);
    path = 8'h00;
    step();
    check("rr_idle", 8'(sel_valid), 8'h00);

    // Backpressure: code 0 held while 7 waits in pending (ptr=0 proves the wrap).
    out_ready = 1'b0;
    path      = 8'h81;
    step();
    check_out("bp0", 3'd0, 1'b1, 8'h80);
    path = 8'h00;
    for (int i = 1; i < 5; i++) begin
      step();
      check_out($sformatf("bp%0d", i), 3'd0, 1'b1, 8'h80);
    end
    out_ready = 1'b1;
    step();
    check_out("bp_rel", 3'd7, 1'b1, 8'h00);
    step();
    check("bp_idle", 8'(sel_valid), 8'h00);

    // Merge: second request for an already-pending bit while output is busy.
    out_ready = 1'b0;
    path      = 8'h02;
    step();
    check_out("mg_busy", 3'd1, 1'b1, 8'h00);
    path = 8'h04;
    step();
    check("mg_first", merge_cnt, 8'd0);
    step();
    check("mg_second", merge_cnt, 8'd1);
    check("mg_pend", pending, 8'h04);
    path      = 8'h00;
    out_ready = 1'b1;
    step();
    check_out("mg_issue", 3'd2, 1'b1, 8'h00);
    step();
    check_out("mg_once", 3'd2, 1'b0, 8'h00);
    check("mg_cnt", merge_cnt, 8'd1);

    // Multi-bit merges add popcount, then saturate.
    out_ready = 1'b0;
    path      = 8'h01;
    step();
    check_out("sat_busy", 3'd0, 1'b1, 8'h00);
    path = 8'h80;
    step();
    path = 8'hC0;
    step();
    check("pop1", merge_cnt, 8'd2);
    step();
    check("pop2", merge_cnt, 8'd4);
    path = 8'h80;
    for (int i = 0; i < 300; i++) step();
    check("sat", merge_cnt, 8'd255);
    path = 8'h30;
    step();
    check("sat_hold", merge_cnt, 8'd255);
    check_out("mid", 3'd0, 1'b1, 8'hF0);

    // Asynchronous reset mid-traffic, observed before the next clock edge.
    path = 8'h00;
    #1;
    rst1 = 1'b1;
    #1;
    check_out("arst", 3'd0, 1'b0, 8'h00);
    check("arst.cnt", merge_cnt, 8'd0);
    #1;
    rst1      = 1'b0;
    out_ready = 1'b1;
    path      = 8'h08;
    step();
    check_out("post_rst", 3'd3, 1'b1, 8'h00);
    path = 8'h00;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
